// File: rtl/y86_pkg.sv
/******************************************************************************
 * Module : y86_pkg
 * Brief  : Y-86 instruction, ALU, condition and status encodings shared by
 *          the execute stage and its ALU.
 * Rev    : 1.0  initial release
 ******************************************************************************/
`default_nettype none

package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] ALUADD = 4'h0;
  localparam logic [3:0] ALUSUB = 4'h1;
  localparam logic [3:0] ALUAND = 4'h2;
  localparam logic [3:0] ALUXOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  // cc is packed {ZF,SF,OF}
  function automatic logic cond_eval(input logic [3:0] fun, input logic [2:0] cc);
    logic zf, sf, of;
    {zf, sf, of} = cc;
    case (fun)
      C_YES:   cond_eval = 1'b1;
      C_LE:    cond_eval = (sf ^ of) | zf;
      C_L:     cond_eval = sf ^ of;
      C_E:     cond_eval = zf;
      C_NE:    cond_eval = ~zf;
      C_GE:    cond_eval = ~(sf ^ of);
      C_G:     cond_eval = ~(sf ^ of) & ~zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/exec_cc_stage_alu64.sv
/******************************************************************************
 * Module : alu64
 * Brief  : Combinational Y-86 ALU (add/sub/and/xor) with ZF/SF/OF flags.
 * Rev    : 1.0  initial release
 ******************************************************************************/
`default_nettype none

module alu64
  import y86_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        fun,
  output logic [DATA_W-1:0] result,
  output logic              zf,
  output logic              sf,
  output logic              of
);

  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;

  assign w_sum  = b + a;
  assign w_diff = b - a;

  always_comb begin
    result = '0;
    of     = 1'b0;
    case (fun)
      ALUADD: begin
        result = w_sum;
        of     = (a[DATA_W-1] == b[DATA_W-1]) && (w_sum[DATA_W-1] != b[DATA_W-1]);
      end
      ALUSUB: begin
        result = w_diff;
        of     = (a[DATA_W-1] != b[DATA_W-1]) && (w_diff[DATA_W-1] != b[DATA_W-1]);
      end
      ALUAND:  result = b & a;
      ALUXOR:  result = b ^ a;
      default: result = '0;
    endcase
  end

  assign zf = (result == '0);
  assign sf = result[DATA_W-1];

endmodule

`default_nettype wire

// File: rtl/exec_cc_stage.sv
/******************************************************************************
 * Module : exec_cc_stage
 * Brief  : Y-86 execute stage: ALU, condition-code register, Cnd evaluation
 *          and a single-entry E/M output register with valid/ready handshake.
 * Rev    : 1.0  initial release
 ******************************************************************************/
`default_nettype none

module exec_cc_stage
  import y86_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [DATA_W-1:0] val_a,
  input  logic [DATA_W-1:0] val_b,
  input  logic [DATA_W-1:0] val_c,
  input  logic [3:0]        dst_e,
  input  logic [2:0]        stat_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val_e_out,
  output logic [DATA_W-1:0] val_a_out,
  output logic [3:0]        dst_e_out,
  output logic              cnd_out,
  output logic [3:0]        icode_out,
  output logic [2:0]        stat_out,
  output logic [2:0]        cc_out
);

  localparam logic [DATA_W-1:0] c_stack_step = DATA_W'(8);
  localparam logic [2:0]        c_cc_reset   = 3'b100;

  logic [DATA_W-1:0] w_alu_a, w_alu_b, w_alu_res;
  logic [3:0]        w_alu_fun;
  logic              w_zf, w_sf, w_of;
  logic              w_accept, w_cnd, w_set_cc;
  logic [3:0]        w_dst;

  logic [DATA_W-1:0] r_val_e, r_val_a;
  logic [3:0]        r_dst_e, r_icode;
  logic              r_cnd, r_valid;
  logic [2:0]        r_stat, r_cc;

  // Every icode's valE is routed through the one ALU; moves add zero
  always_comb begin
    w_alu_a   = '0;
    w_alu_b   = '0;
    w_alu_fun = ALUADD;
    case (icode)
      IOPQ:            begin w_alu_a = val_a; w_alu_b = val_b; w_alu_fun = ifun; end
      IIRMOVQ:         w_alu_a = val_c;
      IRRMOVQ:         w_alu_a = val_a;
      IRMMOVQ,
      IMRMOVQ:         begin w_alu_a = val_c; w_alu_b = val_b; end
      IPUSHQ, ICALL:   begin w_alu_a = c_stack_step; w_alu_b = val_b; w_alu_fun = ALUSUB; end
      IPOPQ, IRET:     begin w_alu_a = c_stack_step; w_alu_b = val_b; end
      default:         ;
    endcase
  end

  alu64 #(.DATA_W(DATA_W)) u_alu (
    .a      (w_alu_a),
    .b      (w_alu_b),
    .fun    (w_alu_fun),
    .result (w_alu_res),
    .zf     (w_zf),
    .sf     (w_sf),
    .of     (w_of)
  );

  assign in_ready = ~r_valid | out_ready;
  assign w_accept = in_valid & in_ready;
  assign w_set_cc = w_accept && (icode == IOPQ) && (stat_in == SAOK);
  assign w_cnd    = ((icode == IRRMOVQ) || (icode == IJXX)) ? cond_eval(ifun, r_cc) : 1'b0;
  assign w_dst    = ((icode == IRRMOVQ) && !w_cnd) ? RNONE : dst_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cc <= c_cc_reset;
    end else if (w_set_cc) begin
      r_cc <= {w_zf, w_sf, w_of};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_val_e <= '0;
      r_val_a <= '0;
      r_dst_e <= '0;
      r_cnd   <= 1'b0;
      r_icode <= '0;
      r_stat  <= SAOK;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_val_e <= w_alu_res;
      r_val_a <= val_a;
      r_dst_e <= w_dst;
      r_cnd   <= w_cnd;
      r_icode <= icode;
      r_stat  <= stat_in;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign val_e_out = r_val_e;
  assign val_a_out = r_val_a;
  assign dst_e_out = r_dst_e;
  assign cnd_out   = r_cnd;
  assign icode_out = r_icode;
  assign stat_out  = r_stat;
  assign cc_out    = r_cc;

endmodule

`default_nettype wire

// File: tb/tb_exec_cc_stage.sv
/******************************************************************************
 * Module : tb_exec_cc_stage
 * Brief  : Directed self-checking bench for exec_cc_stage.
 * Rev    : 1.0  initial release
 ******************************************************************************/
`default_nettype none

module tb_exec_cc_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, cnd_out;
  logic [3:0]  icode, ifun, dst_e, dst_e_out, icode_out;
  logic [63:0] val_a, val_b, val_c, val_e_out, val_a_out;
  logic [2:0]  stat_in, stat_out, cc_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exec_cc_stage #(.DATA_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .icode     (icode),
    .ifun      (ifun),
    .val_a     (val_a),
    .val_b     (val_b),
    .val_c     (val_c),
    .dst_e     (dst_e),
    .stat_in   (stat_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .val_e_out (val_e_out),
    .val_a_out (val_a_out),
    .dst_e_out (dst_e_out),
    .cnd_out   (cnd_out),
    .icode_out (icode_out),
    .stat_out  (stat_out),
    .cc_out    (cc_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [3:0] d, input logic [2:0] st);
    icode = ic; ifun = fn; val_a = a; val_b = b; val_c = c; dst_e = d; stat_in = st;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    drive(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'd1, 3'd1);
    repeat (3) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_cc",    cc_out, 3'b100);
    chk("rst_stat",  stat_out, 3'd1);
    chk("rst_vale",  val_e_out, 0);
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_ready", in_ready, 1);

    // sub 3-2
    in_valid = 1'b1;
    drive(4'h6, 4'h1, 64'd2, 64'd3, 64'd0, 4'd1, 3'd1);
    tick();
    chk("sub_vale",  val_e_out, 64'd1);
    chk("sub_cc",    cc_out, 3'b000);
    chk("sub_valid", out_valid, 1);

    // signed overflow on sub
    drive(4'h6, 4'h1, 64'hFFFF_FFFF_FFFF_FFFB, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'd2, 3'd1);
    tick();
    chk("subov_vale", val_e_out, 64'h8000_0000_0000_0004);
    chk("subov_cc",   cc_out, 3'b011);

    drive(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'd4, 3'd1);
    tick();
    chk("push_vale", val_e_out, 64'hF8);
    chk("push_cc",   cc_out, 3'b011);
    chk("push_cnd",  cnd_out, 0);

    drive(4'h5, 4'h0, 64'd0, 64'h10, 64'h20, 4'd5, 3'd1);
    tick();
    chk("mrm_vale", val_e_out, 64'h30);

    drive(4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 4'd4, 3'd1);
    tick();
    chk("pop_vale", val_e_out, 64'h108);

    // add overflow: max positive + 1
    drive(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'd1, 3'd1);
    tick();
    chk("addov_vale", val_e_out, 64'h8000_0000_0000_0000);
    chk("addov_cc",   cc_out, 3'b011);

    // jg with SF=OF=1, ZF=0 -> taken
    drive(4'h7, 4'h6, 64'd0, 64'd0, 64'h400, 4'hF, 3'd1);
    tick();
    chk("jg_cnd", cnd_out, 1);

    drive(4'h7, 4'h2, 64'd0, 64'd0, 64'h400, 4'hF, 3'd1);
    tick();
    chk("jl_cnd", cnd_out, 0);

    drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'd1, 3'd1);
    tick();
    chk("sub0_vale", val_e_out, 0);
    chk("sub0_cc",   cc_out, 3'b100);

    drive(4'h7, 4'h3, 64'd0, 64'd0, 64'h400, 4'hF, 3'd1);
    tick();
    chk("je_cnd",   cnd_out, 1);
    chk("je_icode", icode_out, 4'h7);

    drive(4'h2, 4'h1, 64'h77, 64'd0, 64'd0, 4'd6, 3'd1);
    tick();
    chk("cmovle_cnd", cnd_out, 1);
    chk("cmovle_dst", dst_e_out, 4'd6);

    drive(4'h2, 4'h4, 64'h55, 64'd0, 64'd0, 4'd3, 3'd1);
    tick();
    chk("cmovne_cnd",  cnd_out, 0);
    chk("cmovne_dst",  dst_e_out, 4'hF);
    chk("cmovne_vale", val_e_out, 64'h55);
    chk("cmovne_vala", val_a_out, 64'h55);

    drive(4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 4'hF, 3'd1);
    tick();
    chk("jbad_cnd", cnd_out, 0);

    // stall: xor held off while memory stage is busy
    out_ready = 1'b0;
    drive(4'h6, 4'h3, 64'h0F, 64'hF0, 64'd0, 4'd2, 3'd1);
    #1;
    chk("stall_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_icode", icode_out, 4'h7);
      chk("stall_cc",    cc_out, 3'b100);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_ready", in_ready, 1);
    tick();
    chk("xor_vale", val_e_out, 64'hFF);
    chk("xor_cc",   cc_out, 3'b000);

    // ADR status: result 0 would set ZF but CC must stay put
    drive(4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'd1, 3'd3);
    tick();
    chk("adr_stat", stat_out, 3'd3);
    chk("adr_cc",   cc_out, 3'b000);
    chk("adr_vale", val_e_out, 0);

    drive(4'hE, 4'h0, 64'h9, 64'h9, 64'h9, 4'd1, 3'd4);
    tick();
    chk("unk_vale", val_e_out, 0);
    chk("unk_cc",   cc_out, 3'b000);

    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    chk("drain_valid", out_valid, 0);

    // reset during a stall, between clock edges
    drive(4'h6, 4'h1, 64'd1, 64'd1, 64'd0, 4'd1, 3'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("prerst_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("asyncrst_valid", out_valid, 0);
    chk("asyncrst_cc",    cc_out, 3'b100);
    chk("asyncrst_stat",  stat_out, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exec_cc_stage.md
Name: exec_cc_stage

Overview:
- Execute stage of the Y-86 pipeline. Sits directly downstream of the decode pipeline register and feeds the memory stage.
- Instantiates the 64-bit ALU (add/sub/and/xor), computes valE, owns the condition-code register (ZF/SF/OF) and evaluates Cnd for jXX/cmovXX.
- Registers its results into a single-entry E/M output register with a valid/ready handshake.

Parameters:
- DATA_W, 64, datapath width (valA/valB/valC/valE).
- RNONE, 4'hF, register ID meaning "no destination".

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode register holds a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- icode  in  4  Y-86 instruction code.
- ifun  in  4  function / condition code.
- val_a  in  DATA_W  operand A.
- val_b  in  DATA_W  operand B.
- val_c  in  DATA_W  immediate / displacement.
- dst_e  in  4  destination register for valE.
- stat_in  in  3  status (1=AOK, 2=HLT, 3=ADR, 4=INS).
- out_valid  out  1  E/M register holds a result.
- out_ready  in  1  memory stage consumes the result.
- val_e_out  out  DATA_W  ALU result.
- val_a_out  out  DATA_W  pass-through valA.
- dst_e_out  out  4  destination; RNONE when cmov fails.
- cnd_out  out  1  condition result.
- icode_out  out  4  pass-through icode.
- stat_out  out  3  pass-through status.
- cc_out  out  3  live CC {ZF,SF,OF}.

Behaviour:
- Reset (async, immediate):
  - out_valid=0; all *_out data = 0; stat_out=1.
  - cc_out=3'b100 (ZF=1, SF=0, OF=0).
  - Reset asserted mid-stall discards the held result.
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational).
  - Accept = in_valid & in_ready. Latency 1 cycle: the accepted instruction's results appear the next cycle with out_valid=1.
  - out_valid & ~out_ready holds all outputs stable; nothing is accepted and CC does not change.
  - Out-going and in-coming in the same cycle is allowed (full throughput).
- ALU operation (val_e), all arithmetic mod 2^64:
  - OPq (6): ifun 0 → valB+valA; 1 → valB−valA; 2 → valB&valA; 3 → valB^valA.
  - irmovq (3): valC.
  - rrmovq/cmovXX (2): valA.
  - rmmovq/mrmovq (4/5): valB+valC.
  - pushq/call (A/8): valB−8.
  - popq/ret (B/9): valB+8.
  - Other icodes: 0.
- Condition codes:
  - Updated only on accept of OPq with stat_in==AOK.
  - ZF = (val_e==0); SF = val_e[63].
  - OF for add: signs of A and B equal and result sign differs.
  - OF for sub (B−A): sign(B)≠sign(A) and sign(result)≠sign(B).
  - OF = 0 for and/xor.
  - Non-AOK status leaves CC unchanged.
- Cnd:
  - Evaluated for icode 2 and 7 from CC *before* this instruction. An OPq accepted in cycle N updates CC so that an instruction accepted in cycle N+1 sees the new value.
  - ifun 0 → 1; 1 (le) → (SF^OF)|ZF; 2 (l) → SF^OF; 3 (e) → ZF; 4 (ne) → ~ZF; 5 (ge) → ~(SF^OF); 6 (g) → ~(SF^OF)&~ZF; ifun>6 → 0.
  - Other icodes: cnd_out=0.
- cmovXX with cnd=0: dst_e_out=RNONE; all other cases pass dst_e through.
- Unknown icode: pass-through only, no CC change.

Decomposition:
- Package y86_pkg holds:
  - icode constants (IHALT..IPOPQ), ALU ifun constants (ALUADD/SUB/AND/XOR) and condition ifun constants.
  - RNONE, and stat codes SAOK/SHLT/SADR/SINS.
- One combinational sub-module alu64 (a, b, fun → result, zf, sf, of) built on the existing 64-bit adder/subtractor.
- This block holds the CC register, cond logic, handshake and E/M register.

Test Plan:
- rst pulse with in_valid=1 → out_valid=0, cc_out=3'b100, in_ready=1 after release.
- OPq sub, valB=3, valA=2 → next cycle val_e_out=1, cc_out=3'b000, out_valid=1.
- OPq sub, valB=64'h7FFF_FFFF_FFFF_FFFF, valA=64'hFFFF_FFFF_FFFF_FFFB → val_e_out=64'h8000_0000_0000_0004, cc_out=3'b011.
- OPq sub 5−5 then back-to-back je (icode 7, ifun 3) → je cnd_out=1. Follow with cmovne (icode 2, ifun 4), dst_e=3 → cnd_out=0, dst_e_out=4'hF.
- out_ready=0 while out_valid=1, in_valid=1 with OPq xor → in_ready=0; outputs and cc_out frozen for 3 cycles; accept on the cycle out_ready rises.
- OPq add with stat_in=3 (ADR) → stat_out=3, cc_out unchanged. Assert rst during a stall → out_valid drops with no clock edge.
